// File: rtl/adc_input_axi_write_if.sv
// adc_input_axi_write_if: AXI4-Lite write-channel bundle between a master and the ADC write slave
interface adc_input_axi_write_if;
  logic [31:0] AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    input  AWREADY, WREADY, BRESP, BVALID
  );
  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY,
    output AWREADY, WREADY, BRESP, BVALID
  );
endinterface

// File: rtl/adc_input_axi_write.sv
// adc_input_axi_write: AXI4-Lite write slave holding the ADC core control/config registers
module adc_input_axi_write #(
  parameter logic [31:0] C_BASEADDR    = 32'd0,
  parameter logic [31:0] C_HIGHADDR    = 32'd0,
  parameter logic [31:0] C_DSIZE_RESET = 32'd1024
) (
  input  logic                 ACLK,
  input  logic                 ARESET,
  adc_input_axi_write_if.slave s,
  output logic                 cr_test,
  output logic [31:0]          dsize,
  output logic                 sr_pc_clr
);
  typedef enum logic [1:0] {S_IDLE, S_WR, S_RESP} state_t;
  state_t      state;
  logic        aw_held, w_held, awready, wready, bvalid;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        aw_hs, w_hs, unused_high;
  assign aw_hs       = s.AWVALID && awready;
  assign w_hs        = s.WVALID && wready;
  assign s.AWREADY   = awready;
  assign s.WREADY    = wready;
  assign s.BVALID    = bvalid;
  assign s.BRESP     = 2'b00;
  assign unused_high = ^C_HIGHADDR;
  // collect AW/W in any order, commit for one cycle, then hold the response until BREADY
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state     <= S_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      awready   <= 1'b1;
      wready    <= 1'b1;
      bvalid    <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      wstrb     <= '0;
      cr_test   <= 1'b0;
      dsize     <= C_DSIZE_RESET;
      sr_pc_clr <= 1'b0;
    end else begin
      sr_pc_clr <= 1'b0;
      case (state)
        S_IDLE: begin
          if (aw_hs) begin
            addr    <= s.AWADDR;
            aw_held <= 1'b1;
            awready <= 1'b0;
          end
          if (w_hs) begin
            wdata  <= s.WDATA;
            wstrb  <= s.WSTRB;
            w_held <= 1'b1;
            wready <= 1'b0;
          end
          if ((aw_held || aw_hs) && (w_held || w_hs)) begin
            state   <= S_WR;
            awready <= 1'b0;
            wready  <= 1'b0;
          end
        end
        S_WR: begin
          if (addr == C_BASEADDR && wstrb[0]) cr_test <= wdata[0];
          sr_pc_clr <= addr == C_BASEADDR + 32'd4 && wstrb[0] && wdata[0];
          if (addr == C_BASEADDR + 32'd8)
            for (int i = 0; i < 4; i++)
              if (wstrb[i]) dsize[8*i +: 8] <= wdata[8*i +: 8];
          aw_held <= 1'b0;
          w_held  <= 1'b0;
          bvalid  <= 1'b1;
          state   <= S_RESP;
        end
        S_RESP: begin
          if (s.BREADY) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            wready  <= 1'b1;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_adc_input_axi_write.sv
// tb_adc_input_axi_write: directed vectors for the ADC AXI4-Lite write slave
module tb_adc_input_axi_write;
  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        cr_test, sr_pc_clr;
  logic [31:0] dsize;
  int          vectors = 0, miscompares = 0, pulses = 0;
  adc_input_axi_write_if bus ();
  adc_input_axi_write #(.C_BASEADDR(32'h0), .C_HIGHADDR(32'hFF), .C_DSIZE_RESET(32'd1024)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .s(bus.slave),
    .cr_test(cr_test), .dsize(dsize), .sr_pc_clr(sr_pc_clr)
  );
  always #5 ACLK = ~ACLK;
  // count clear pulses by cycles they are high
  always @(negedge ACLK) if (sr_pc_clr) pulses++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
    int n;
    bus.AWADDR = a; bus.WDATA = d; bus.WSTRB = st;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.BREADY = 1'b1;
    step();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    n = 0;
    while (!bus.BVALID && n < 10) begin
      step();
      n++;
    end
    check("bvalid_timeout", 32'(bus.BVALID), 32'd1);
    check("bresp", 32'(bus.BRESP), 32'd0);
    step();
  endtask
  initial begin
    int p0;
    bus.AWADDR = '0; bus.WDATA = '0; bus.WSTRB = '0;
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    ARESET = 1'b1;
    step(); step();
    ARESET = 1'b0;
    check("rst_dsize", dsize, 32'h400);
    check("rst_cr", 32'(cr_test), 32'd0);
    check("rst_awready", 32'(bus.AWREADY), 32'd1);
    check("rst_wready", 32'(bus.WREADY), 32'd1);
    check("rst_bvalid", 32'(bus.BVALID), 32'd0);
    check("rst_sr", 32'(sr_pc_clr), 32'd0);
    // simultaneous AW/W to DSIZE
    bus.AWADDR = 32'h8; bus.WDATA = 32'h1234; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.BREADY = 1'b1;
    step();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    check("wr_dsize_old", dsize, 32'h400);
    check("wr_awready", 32'(bus.AWREADY), 32'd0);
    check("wr_bvalid", 32'(bus.BVALID), 32'd0);
    step();
    check("ds_dsize", dsize, 32'h1234);
    check("ds_bvalid", 32'(bus.BVALID), 32'd1);
    step();
    check("ds_bvalid_off", 32'(bus.BVALID), 32'd0);
    check("ds_awready_back", 32'(bus.AWREADY), 32'd1);
    check("ds_wready_back", 32'(bus.WREADY), 32'd1);
    // W three cycles ahead of AW, to CR
    bus.WDATA = 32'h1; bus.WSTRB = 4'h1; bus.WVALID = 1'b1;
    step();
    bus.WVALID = 1'b0;
    check("wf_wready", 32'(bus.WREADY), 32'd0);
    check("wf_awready", 32'(bus.AWREADY), 32'd1);
    step(); step();
    check("wf_cr_wait", 32'(cr_test), 32'd0);
    check("wf_bvalid_wait", 32'(bus.BVALID), 32'd0);
    bus.AWADDR = 32'h0; bus.AWVALID = 1'b1;
    step();
    bus.AWVALID = 1'b0;
    check("wf_cr_swr", 32'(cr_test), 32'd0);
    step();
    check("wf_cr", 32'(cr_test), 32'd1);
    check("wf_bvalid", 32'(bus.BVALID), 32'd1);
    check("wf_bresp", 32'(bus.BRESP), 32'd0);
    step();
    check("wf_bvalid_off", 32'(bus.BVALID), 32'd0);
    // byte-strobed DSIZE update
    axi_write(32'h8, 32'hFFFF_FFFF, 4'hF);
    check("strb_full", dsize, 32'hFFFF_FFFF);
    axi_write(32'h8, 32'h0000_00AB, 4'h1);
    check("strb_byte0", dsize, 32'hFFFF_FFAB);
    axi_write(32'h8, 32'h0011_2200, 4'h6);
    check("strb_mid", dsize, 32'hFF11_22AB);
    // SR write-1-to-clear pulse
    p0 = pulses;
    axi_write(32'h4, 32'h1, 4'h1);
    check("sr_pulse1", 32'(pulses - p0), 32'd1);
    check("sr_low_after", 32'(sr_pc_clr), 32'd0);
    p0 = pulses;
    axi_write(32'h4, 32'h0, 4'hF);
    check("sr_pulse0", 32'(pulses - p0), 32'd0);
    p0 = pulses;
    axi_write(32'h4, 32'h1, 4'h2);
    check("sr_nostrb", 32'(pulses - p0), 32'd0);
    // unmapped addresses
    axi_write(32'hC, 32'hDEAD_BEEF, 4'hF);
    check("unmap_c_dsize", dsize, 32'hFF11_22AB);
    check("unmap_c_cr", 32'(cr_test), 32'd1);
    axi_write(32'h100, 32'h0, 4'hF);
    check("unmap_100_dsize", dsize, 32'hFF11_22AB);
    check("unmap_100_cr", 32'(cr_test), 32'd1);
    axi_write(32'h0, 32'h0, 4'h0);
    check("cr_nostrb", 32'(cr_test), 32'd1);
    axi_write(32'h0, 32'h0, 4'h1);
    check("cr_clear", 32'(cr_test), 32'd0);
    // BREADY held low for 5 cycles
    bus.AWADDR = 32'h8; bus.WDATA = 32'h55; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1; bus.BREADY = 1'b0;
    step();
    bus.WDATA = 32'h66;
    step();
    check("bp_dsize", dsize, 32'h55);
    for (int i = 0; i < 5; i++) begin
      check("bp_bvalid", 32'(bus.BVALID), 32'd1);
      check("bp_awready", 32'(bus.AWREADY), 32'd0);
      check("bp_wready", 32'(bus.WREADY), 32'd0);
      step();
    end
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b1;
    step();
    check("bp_bvalid_off", 32'(bus.BVALID), 32'd0);
    check("bp_dsize_kept", dsize, 32'h55);
    check("bp_awready_back", 32'(bus.AWREADY), 32'd1);
    // reset while in S_WR aborts the write
    axi_write(32'h0, 32'h1, 4'h1);
    p0 = pulses;
    bus.AWADDR = 32'h8; bus.WDATA = 32'h77; bus.WSTRB = 4'hF;
    bus.AWVALID = 1'b1; bus.WVALID = 1'b1;
    step();
    bus.AWVALID = 1'b0; bus.WVALID = 1'b0;
    ARESET = 1'b1;
    step();
    ARESET = 1'b0;
    check("abort_dsize", dsize, 32'h400);
    check("abort_bvalid", 32'(bus.BVALID), 32'd0);
    check("abort_cr", 32'(cr_test), 32'd0);
    step();
    check("abort_bvalid_late", 32'(bus.BVALID), 32'd0);
    check("abort_dsize_late", dsize, 32'h400);
    check("abort_awready", 32'(bus.AWREADY), 32'd1);
    check("abort_pulses", 32'(pulses - p0), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
